// File: rtl/mem_arbiter_if.sv
// Bundle of requester, memory-side and stall signals for mem_arbiter.
// slave is the arbiter's view; master is the view of the surrounding system.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic              iif_req;
  logic [AW-1:0]     iif_addr;
  logic              oif_gnt;
  logic              oif_rvalid;
  logic [DW-1:0]     oif_rdata;

  logic              idm_req;
  logic              idm_we;
  logic [DW/8-1:0]   idm_be;
  logic [AW-1:0]     idm_addr;
  logic [DW-1:0]     idm_wdata;
  logic              odm_gnt;
  logic              odm_rvalid;
  logic [DW-1:0]     odm_rdata;

  logic              omem_req;
  logic              omem_we;
  logic [DW/8-1:0]   omem_be;
  logic [AW-1:0]     omem_addr;
  logic [DW-1:0]     omem_wdata;
  logic              imem_ready;
  logic              imem_rvalid;
  logic [DW-1:0]     imem_rdata;

  logic              ostall_f;
  logic              ostall_m;

  modport slave (
    input  iif_req, iif_addr, idm_req, idm_we, idm_be, idm_addr, idm_wdata,
    input  imem_ready, imem_rvalid, imem_rdata,
    output oif_gnt, oif_rvalid, oif_rdata, odm_gnt, odm_rvalid, odm_rdata,
    output omem_req, omem_we, omem_be, omem_addr, omem_wdata, ostall_f, ostall_m
  );

  modport master (
    output iif_req, iif_addr, idm_req, idm_we, idm_be, idm_addr, idm_wdata,
    output imem_ready, imem_rvalid, imem_rdata,
    input  oif_gnt, oif_rvalid, oif_rdata, odm_gnt, odm_rvalid, odm_rdata,
    input  omem_req, omem_we, omem_be, omem_addr, omem_wdata, ostall_f, ostall_m
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between an instruction-fetch and a data requester,
// one transaction in flight, data-first with a starvation escape for fetch.
//
// state | meaning
// IDLE  | no transaction; grant one requester combinationally
// ISSUE | omem_req high with latched fields until imem_ready
// WAIT  | accepted; wait for imem_rvalid, then pulse owner's rvalid
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic iclk,
  input  logic irst_n,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  localparam int          BW  = DW / 8;
  localparam logic [3:0]  LIM = 4'(STARVE_LIM);

  state_e          state_q, state_d;
  logic [3:0]      starve_q, starve_d;
  logic            owner_q, owner_d;
  logic            we_q, we_d;
  logic [BW-1:0]   be_q, be_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            f_rvalid_q, f_rvalid_d;
  logic            d_rvalid_q, d_rvalid_d;
  logic [DW-1:0]   f_rdata_q, f_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            gnt_f, gnt_m;

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    owner_d    = owner_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    f_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    f_rdata_d  = f_rdata_q;
    d_rdata_d  = d_rdata_q;
    gnt_f      = 1'b0;
    gnt_m      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.idm_req && !(bus.iif_req && starve_q == LIM)) begin
          gnt_m   = 1'b1;
          owner_d = 1'b1;
          we_d    = bus.idm_we;
          be_d    = bus.idm_be;
          addr_d  = bus.idm_addr;
          wdata_d = bus.idm_wdata;
          state_d = ISSUE;
          // fetch lost while below the limit, so this never passes LIM
          if (bus.iif_req) starve_d = starve_q + 4'd1;
        end else if (bus.iif_req) begin
          gnt_f    = 1'b1;
          owner_d  = 1'b0;
          we_d     = 1'b0;
          be_d     = '1;
          addr_d   = bus.iif_addr;
          wdata_d  = '0;
          starve_d = 4'd0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.imem_ready) state_d = WAIT;
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          state_d = IDLE;
          if (owner_q) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = bus.imem_rdata;
          end else begin
            f_rvalid_d = 1'b1;
            f_rdata_d  = bus.imem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      state_q    <= IDLE;
      starve_q   <= 4'd0;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      f_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      f_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      f_rvalid_q <= f_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      f_rdata_q  <= f_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign bus.oif_gnt    = gnt_f & irst_n;
  assign bus.odm_gnt    = gnt_m & irst_n;
  assign bus.omem_req   = (state_q == ISSUE);
  assign bus.omem_we    = we_q;
  assign bus.omem_be    = be_q;
  assign bus.omem_addr  = addr_q;
  assign bus.omem_wdata = wdata_q;
  assign bus.oif_rvalid = f_rvalid_q;
  assign bus.oif_rdata  = f_rdata_q;
  assign bus.odm_rvalid = d_rvalid_q;
  assign bus.odm_rdata  = d_rdata_q;
  assign bus.ostall_f   = bus.iif_req & ~f_rvalid_q;
  assign bus.ostall_m   = bus.idm_req & ~d_rvalid_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: queued requesters, a latency-programmable
// memory responder and a transaction-level model compared every cycle.
module tb_mem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int LIM = 4;

  logic iclk = 1'b0;
  logic irst_n = 1'b0;
  always #5 iclk = ~iclk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus();

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIM(LIM)) dut (
    .iclk  (iclk),
    .irst_n(irst_n),
    .bus   (bus.slave)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
  } dop_t;

  logic [AW-1:0] fq[$];
  dop_t          dq[$];
  bit            f_taken = 0, d_taken = 0;

  // requesters: hold the queue head until granted, then present the next one
  always @(negedge iclk) begin
    if (bus.oif_gnt === 1'b1) f_taken = 1;
    if (bus.odm_gnt === 1'b1) d_taken = 1;
  end

  always @(posedge iclk) begin
    #2;
    if (f_taken) begin if (fq.size() > 0) void'(fq.pop_front()); f_taken = 0; end
    if (d_taken) begin if (dq.size() > 0) void'(dq.pop_front()); d_taken = 0; end
    bus.iif_req  = (fq.size() > 0);
    bus.iif_addr = (fq.size() > 0) ? fq[0] : 32'h0BAD_0F00;
    if (dq.size() > 0) begin
      bus.idm_req   = 1'b1;
      bus.idm_addr  = dq[0].addr;
      bus.idm_we    = dq[0].we;
      bus.idm_be    = dq[0].be;
      bus.idm_wdata = dq[0].wdata;
    end else begin
      bus.idm_req   = 1'b0;
      bus.idm_addr  = 32'h0BAD_0D00;
      bus.idm_we    = 1'b1;
      bus.idm_be    = 4'h9;
      bus.idm_wdata = 32'hFFFF_0000;
    end
  end

  // memory responder; imem_ready is held high whenever no request is shown
  int            ready_lat = 0, rv_lat = 0, rdy_cnt = 0, rv_cnt = 0;
  bit            pend = 0, stray_rv = 0;
  logic [DW-1:0] rd_val = 32'h1000_0001;

  initial begin
    bus.iif_req = 0; bus.iif_addr = '0; bus.idm_req = 0; bus.idm_we = 0;
    bus.idm_be = '0; bus.idm_addr = '0; bus.idm_wdata = '0;
    bus.imem_ready = 0; bus.imem_rvalid = 0; bus.imem_rdata = '0;
  end

  always @(posedge iclk) begin
    #2;
    bus.imem_rvalid = stray_rv;
    if (!irst_n) begin
      pend = 0; rdy_cnt = 0; bus.imem_ready = 1'b0;
    end else begin
      if (pend) begin
        if (rv_cnt >= rv_lat) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = rd_val;
          rd_val          = rd_val + 32'h0101_0101;
          pend            = 0;
        end else rv_cnt++;
      end
      if (bus.omem_req === 1'b1) begin
        if (rdy_cnt >= ready_lat) begin
          bus.imem_ready = 1'b1; rdy_cnt = 0; pend = 1; rv_cnt = 0;
        end else begin
          bus.imem_ready = 1'b0; rdy_cnt++;
        end
      end else bus.imem_ready = 1'b1;
    end
  end

  // transaction-level model: one record for the access in flight
  bit            m_busy = 0, m_acc = 0, m_own_d = 0;
  logic [AW-1:0] m_addr = '0;
  logic          m_we = 0;
  logic [BW-1:0] m_be = '0;
  logic [DW-1:0] m_wdata = '0;
  int            m_lost = 0;
  bit            m_frv = 0, m_drv = 0;
  logic [DW-1:0] m_frd = '0, m_drd = '0;

  always @(negedge iclk) begin
    bit eg_d, eg_f;
    eg_d = irst_n && !m_busy && bus.idm_req && !(bus.iif_req && m_lost >= LIM);
    eg_f = irst_n && !m_busy && bus.iif_req && !eg_d;
    chk("odm_gnt", bus.odm_gnt, eg_d);
    chk("oif_gnt", bus.oif_gnt, eg_f);
    chk("omem_req", bus.omem_req, m_busy && !m_acc);
    if (m_busy && !m_acc) begin
      chk("omem_addr", bus.omem_addr, m_addr);
      chk("omem_we", bus.omem_we, m_we);
      chk("omem_be", bus.omem_be, m_be);
      chk("omem_wdata", bus.omem_wdata, m_wdata);
    end
    chk("oif_rvalid", bus.oif_rvalid, m_frv);
    chk("odm_rvalid", bus.odm_rvalid, m_drv);
    chk("oif_rdata", bus.oif_rdata, m_frd);
    chk("odm_rdata", bus.odm_rdata, m_drd);
    chk("ostall_f", bus.ostall_f, bus.iif_req && !m_frv);
    chk("ostall_m", bus.ostall_m, bus.idm_req && !m_drv);
    if (!irst_n) begin
      m_busy = 0; m_acc = 0; m_own_d = 0; m_lost = 0;
      m_frv = 0; m_drv = 0; m_frd = '0; m_drd = '0;
    end else begin
      m_frv = 0; m_drv = 0;
      if (m_busy && m_acc) begin
        if (bus.imem_rvalid) begin
          if (m_own_d) begin m_drv = 1; m_drd = bus.imem_rdata; end
          else begin m_frv = 1; m_frd = bus.imem_rdata; end
          m_busy = 0;
        end
      end else if (m_busy) begin
        if (bus.imem_ready) m_acc = 1;
      end else if (eg_d) begin
        m_busy = 1; m_acc = 0; m_own_d = 1;
        m_addr = bus.idm_addr; m_we = bus.idm_we; m_be = bus.idm_be; m_wdata = bus.idm_wdata;
        if (bus.iif_req) m_lost = (m_lost + 1 > LIM) ? LIM : m_lost + 1;
      end else if (eg_f) begin
        m_busy = 1; m_acc = 0; m_own_d = 0;
        m_addr = bus.iif_addr; m_we = 0; m_be = '1; m_wdata = '0;
        m_lost = 0;
      end
    end
  end

  task automatic drain();
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge iclk);
      if (fq.size() == 0 && dq.size() == 0 && !m_busy && !bus.iif_req && !bus.idm_req) break;
    end
    chk("drain_in_time", k < 100, 1);
    @(posedge iclk); #1;
  endtask

  task automatic wait_gnt(input bit data, input string nm);
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge iclk);
      if (data ? bus.odm_gnt : bus.oif_gnt) break;
    end
    chk(nm, k < 40, 1);
  endtask

  function automatic dop_t mk(input logic [AW-1:0] a, input logic w, input logic [BW-1:0] b,
                              input logic [DW-1:0] d);
    dop_t r;
    r.addr = a; r.we = w; r.be = b; r.wdata = d;
    return r;
  endfunction

  initial begin
    logic [9:0] seq;
    int cnt;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] seq;
    int cnt;
    // reset with a pending data request: no grant may escape
    irst_n = 1'b0;
    @(posedge iclk); #1;
    dq.push_back(mk(32'h300, 1'b0, 4'hF, 32'h0));
    repeat (2) @(negedge iclk);
    chk("rst_odm_gnt", bus.odm_gnt, 0);
    chk("rst_omem_req", bus.omem_req, 0);
    chk("rst_rdata", {bus.oif_rdata, bus.odm_rdata}, 0);
    @(posedge iclk); #1;
    irst_n = 1'b1;
    wait_gnt(1, "post_rst_gnt");
    drain();

    // fetch only
    rd_val = 32'hDEAD_BEEF;
    fq.push_back(32'h100);
    @(negedge iclk); chk("f_gnt_c0", bus.oif_gnt, 1);
    @(negedge iclk);
    chk("f_req_c1", bus.omem_req, 1);
    chk("f_addr_c1", bus.omem_addr, 32'h100);
    chk("f_we_be_c1", {bus.omem_we, bus.omem_be}, 5'h0F);
    @(negedge iclk);
    @(negedge iclk);
    chk("f_rvalid_c3", bus.oif_rvalid, 1);
    chk("f_rdata_c3", bus.oif_rdata, 32'hDEAD_BEEF);
    drain();

    // simultaneous: data store first, fetch back-to-back
    dq.push_back(mk(32'h200, 1'b1, 4'h3, 32'h55));
    fq.push_back(32'h204);
    @(negedge iclk); chk("both_first_is_data", {bus.odm_gnt, bus.oif_gnt}, 2'b10);
    @(negedge iclk);
    chk("st_we_be", {bus.omem_we, bus.omem_be}, 5'h13);
    chk("st_wdata", bus.omem_wdata, 32'h55);
    @(negedge iclk);
    @(negedge iclk);
    chk("st_ack", bus.odm_rvalid, 1);
    chk("fetch_back_to_back", bus.oif_gnt, 1);
    drain();

    // starvation: expect D D D D F D D D D F
    for (int i = 0; i < 8; i++) dq.push_back(mk(32'h400 + 4*i, 1'b0, 4'hF, 32'h0));
    fq.push_back(32'h800); fq.push_back(32'h804);
    seq = '0;
    for (int g = 0; g < 10; g++) begin
      int k;
      for (k = 0; k < 20; k++) begin
        @(negedge iclk);
        if (bus.odm_gnt || bus.oif_gnt) break;
      end
      seq = {seq[8:0], bus.odm_gnt};
    end
    chk("starve_order", seq, 10'b1111011110);
    drain();

    // backpressure: five cycles of imem_ready low in ISSUE
    ready_lat = 5;
    dq.push_back(mk(32'h900, 1'b1, 4'hC, 32'hA5A5_5A5A));
    fq.push_back(32'h904);
    wait_gnt(1, "bp_gnt");
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge iclk);
      if (!bus.omem_req) break;
      cnt++;
      chk("bp_stall_f", bus.ostall_f, 1);
      chk("bp_addr_stable", bus.omem_addr, 32'h900);
    end
    chk("bp_req_cycles", cnt, 6);
    ready_lat = 0;
    drain();

    // reset while waiting for the response, then a late response
    rv_lat = 20;
    fq.push_back(32'hA00);
    wait_gnt(0, "rw_gnt");
    repeat (2) @(negedge iclk);
    @(posedge iclk); #1; irst_n = 1'b0;
    repeat (2) begin @(posedge iclk); #1; end
    irst_n = 1'b1;
    @(posedge iclk); #1; stray_rv = 1;
    @(posedge iclk); #1; stray_rv = 0;
    rv_lat = 0;
    cnt = 0;
    repeat (4) begin @(negedge iclk); cnt += bus.oif_rvalid + bus.odm_rvalid; end
    chk("late_rv_ignored", cnt, 0);
    @(posedge iclk); #1;
    fq.push_back(32'hA04);
    @(negedge iclk); chk("post_rst_fetch_gnt", bus.oif_gnt, 1);
    drain();

    // stray response in IDLE
    stray_rv = 1;
    @(negedge iclk); chk("stray_no_rvalid", {bus.oif_rvalid, bus.odm_rvalid}, 0);
    @(posedge iclk); #1; stray_rv = 0;
    @(negedge iclk); chk("stray_no_rvalid_next", {bus.oif_rvalid, bus.odm_rvalid}, 0);
    @(posedge iclk); #1;
    dq.push_back(mk(32'hB00, 1'b0, 4'hF, 32'h0));
    @(negedge iclk); chk("stray_then_gnt", bus.odm_gnt, 1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
